alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Second-generation ALU control unit for the RISC-V core. It decodes ALUOp/func3/func7/opcode bits into an ALU select over a wider operation set: base ops plus SLT, SLTU and LUI pass-through. It also sequences RV32M multiply/divide instructions onto an external multi-cycle muldiv unit through a start/done handshake. It sits between the main control unit and the datapath, and drives the pipeline stall and writeback result-select lines.

## Interface
Parameters:
- ALUSEL_WIDTH, 4, width of ALUSel (must be ≥4)
- MD_TIMEOUT, 64, max cycles spent waiting for md_done before abort (≥2)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  decode fields below describe a live instruction
- ALUOp  in  3  0=RI, 1=JALR, 2=S, 3=SB, 4=U, 5=UJ, others reserved
- func3  in  3  instruction funct3
- func7_bit5  in  1  instr[30]
- func7_bit0  in  1  instr[25]; M-extension marker
- opcode_bit5  in  1  instr[5]
- ALUSel  out  ALUSEL_WIDTH  ALU operation select, combinational
- md_start  out  1  one-cycle start pulse to muldiv unit, registered
- md_op  out  3  muldiv operation (= func3), registered, held through the op
- md_done  in  1  muldiv result valid
- stall  out  1  hold PC and pipeline registers
- md_result_sel  out  1  writeback selects muldiv result
- md_error  out  1  sticky timeout flag

## Operation
- ALUSel encoding: ADD=0, SUB=1, SLL=2, XOR=3, SRL=4, SRA=5, OR=6, AND=7, SLT=8, SLTU=9, PASSB=10. Upper bits are zero-extended when ALUSEL_WIDTH>4.
- ALUOp=RI, func3 decode:
  - 000: SUB if opcode_bit5 & func7_bit5, else ADD.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRA if func7_bit5, else SRL.
  - 110: OR. 111: AND.
- Loads and stores are issued with ALUOp=S, so func3=010 under RI is always SLT.
- ALUOp=U: PASSB if opcode_bit5 (LUI), else ADD (AUIPC).
- ALUOp JALR, S, SB, UJ: ADD. Reserved ALUOp: ADD.
- M op = instr_valid & ALUOp==RI & opcode_bit5 & func7_bit0. During an M op ALUSel=ADD.
- FSM states IDLE, BUSY, DONE; reset state IDLE.
  - IDLE: stall = M op (combinational). On M op: go to BUSY, md_start<=1, md_op<=func3, counter<=0.
  - BUSY: stall=1; md_start<=0; counter increments every cycle.
    - md_done=1 → DONE.
    - Otherwise, counter==MD_TIMEOUT-1 → md_error<=1, then DONE.
  - DONE: stall=0, md_result_sel=1, then IDLE unconditionally. The pipeline advances at the end of DONE, so the held instruction is not re-issued.
- md_done is ignored in IDLE and DONE.
- instr_valid or field changes while in BUSY are ignored; md_op stays held.
- md_error stays 1 until rst. It does not block later M ops.
- Counter width is $clog2(MD_TIMEOUT); it never wraps, because the timeout exits BUSY first.

## Timing
- Reset values: state=IDLE, md_start=0, md_op=0, counter=0, md_error=0. Hence stall=0 and md_result_sel=0 until an M op appears. ALUSel follows its inputs.
- rst asserted mid-operation returns to IDLE immediately (asynchronous) and drops md_start and stall; it does not wait for a clock edge.
- Non-M instructions: zero-latency combinational decode, no stall.
- M op, cycle N (IDLE): stall=1.
- Cycle N+1 (BUSY): md_start=1 for exactly this cycle. md_done may already be 1 here and is accepted.
- Fastest retirement: DONE at N+2, IDLE at N+3. Total 3 cycles held.
- md_done first seen at cycle N+k (k≥1) → DONE at N+k+1.
- Timeout: with no md_done, BUSY spans N+1 … N+MD_TIMEOUT. md_error rises and DONE is entered at N+MD_TIMEOUT+1.
- md_done asserted in the same cycle the counter reaches MD_TIMEOUT-1: done wins and md_error stays 0.
- Back-to-back M ops: the second is detected in the cycle after DONE (IDLE), giving a fresh start pulse.

## Test plan
- Base decode: sweep all ALUOp/func3/func7_bit5/opcode_bit5 combos with instr_valid=0 → e.g. RI, func3=011 → 9; RI, func3=000, bit5s=1/1 → 1; U with opcode_bit5=1 → 10 and with 0 → 0; JALR → 0.
- MUL with md_done pulsed 3 cycles after md_start → stall high for 5 cycles, md_start exactly 1 cycle, md_op=000, md_result_sel=1 only in DONE, md_error=0.
- DIVU with md_done in the md_start cycle → stall for 2 cycles, DONE on the 3rd cycle; a stray md_done in IDLE is ignored.
- MD_TIMEOUT=8 with md_done never asserted → md_error=1 on entering DONE (cycle N+9) and stays 1 through a later successful MUL until rst.
- Two back-to-back REM ops → two distinct md_start pulses separated by DONE and IDLE; the second md_op=110.
- rst asserted asynchronously in the middle of BUSY → stall and md_start drop without a clock edge; state is IDLE and counter is 0 after release.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder plus RV32M sequencer: decodes ALUOp/func fields into an ALU select
// and hands multiply/divide instructions to an external muldiv unit, stalling the pipeline.
module alu_ctrl_seq #(
  parameter int unsigned ALUSEL_WIDTH = 4,
  parameter int unsigned MD_TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [2:0]              ALUOp,
  input  logic [2:0]              func3,
  input  logic                    func7_bit5,
  input  logic                    func7_bit0,
  input  logic                    opcode_bit5,
  output logic [ALUSEL_WIDTH-1:0] ALUSel,
  output logic                    md_start,
  output logic [2:0]              md_op,
  input  logic                    md_done,
  output logic                    stall,
  output logic                    md_result_sel,
  output logic                    md_error
);

  localparam int unsigned CNT_W = $clog2(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_XOR   = 4'd3,
    OP_SRL   = 4'd4,
    OP_SRA   = 4'd5,
    OP_OR    = 4'd6,
    OP_AND   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_PASSB = 4'd10
  } alu_sel_e;

  typedef enum logic [2:0] {
    ALUOP_RI   = 3'd0,
    ALUOP_JALR = 3'd1,
    ALUOP_S    = 3'd2,
    ALUOP_SB   = 3'd3,
    ALUOP_U    = 3'd4,
    ALUOP_UJ   = 3'd5
  } aluop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             md_start_q;
  logic [2:0]       md_op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             md_error_q;

  logic             m_op;
  alu_sel_e         sel;

  assign m_op = instr_valid & (ALUOp == ALUOP_RI) & opcode_bit5 & func7_bit0;

  always_comb begin
    sel = OP_ADD;
    case (ALUOp)
      ALUOP_RI: begin
        case (func3)
          3'b000:  sel = (opcode_bit5 & func7_bit5) ? OP_SUB : OP_ADD;
          3'b001:  sel = OP_SLL;
          3'b010:  sel = OP_SLT;
          3'b011:  sel = OP_SLTU;
          3'b100:  sel = OP_XOR;
          3'b101:  sel = func7_bit5 ? OP_SRA : OP_SRL;
          3'b110:  sel = OP_OR;
          default: sel = OP_AND;
        endcase
      end
      ALUOP_U: sel = opcode_bit5 ? OP_PASSB : OP_ADD;
      default: sel = OP_ADD;
    endcase
    // M ops reuse the RI encoding; the ALU result is discarded, so keep it on ADD
    if (m_op) begin
      sel = OP_ADD;
    end
  end

  assign ALUSel = ALUSEL_WIDTH'(sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      md_start_q <= 1'b0;
      md_op_q    <= '0;
      cnt_q      <= '0;
      md_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (m_op) begin
            state_q    <= S_BUSY;
            md_start_q <= 1'b1;
            md_op_q    <= func3;
            cnt_q      <= '0;
          end
        end
        S_BUSY: begin
          md_start_q <= 1'b0;
          // done has priority over a timeout landing in the same cycle
          if (md_done) begin
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            md_error_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall         = 1'b0;
    md_result_sel = 1'b0;
    unique case (state_q)
      S_IDLE:  stall = m_op;
      S_BUSY:  stall = 1'b1;
      S_DONE:  md_result_sel = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign md_start = md_start_q;
  assign md_op    = md_op_q;
  assign md_error = md_error_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: decode vector table, hand-written muldiv sequences and a
// randomized run, all checked against a behavioural model kept here.
module tb_alu_ctrl_seq;

  localparam int unsigned AW = 5;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic [2:0]    ALUOp;
  logic [2:0]    func3;
  logic          func7_bit5;
  logic          func7_bit0;
  logic          opcode_bit5;
  logic [AW-1:0] ALUSel;
  logic          md_start;
  logic [2:0]    md_op;
  logic          md_done;
  logic          stall;
  logic          md_result_sel;
  logic          md_error;

  alu_ctrl_seq #(.ALUSEL_WIDTH(AW), .MD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .ALUOp(ALUOp), .func3(func3),
    .func7_bit5(func7_bit5), .func7_bit0(func7_bit0), .opcode_bit5(opcode_bit5),
    .ALUSel(ALUSel), .md_start(md_start), .md_op(md_op), .md_done(md_done),
    .stall(stall), .md_result_sel(md_result_sel), .md_error(md_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // behavioural model: age = cycles spent waiting on the muldiv unit (0 = not waiting)
  int         age;
  bit         done_m;
  bit         start_m;
  bit         err_m;
  logic [2:0] op_m;

  logic [AW-1:0] last_sel;
  logic last_stall, last_start, last_rsel, last_err;
  logic [2:0] last_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ref_sel(input bit v, input logic [2:0] aop, input logic [2:0] f3,
                                            input bit f7b5, input bit f7b0, input bit opb5);
    int unsigned rt [8];
    int unsigned r;
    rt = '{0, 2, 8, 9, 3, 4, 6, 7};
    r = 0;
    if (aop == 3'd0) begin
      r = rt[f3];
      if (f3 == 3'd0 && opb5 && f7b5) r = 1;
      if (f3 == 3'd5 && f7b5) r = 5;
      if (v && opb5 && f7b0) r = 0;
    end else if (aop == 3'd4) begin
      r = opb5 ? 10 : 0;
    end
    return AW'(r);
  endfunction

  task automatic model_reset();
    age = 0; done_m = 0; start_m = 0; err_m = 0; op_m = 3'd0;
  endtask

  task automatic cycle(input bit v, input logic [2:0] aop, input logic [2:0] f3,
                       input bit f7b5, input bit f7b0, input bit opb5, input bit done);
    bit mop;
    instr_valid = v; ALUOp = aop; func3 = f3; func7_bit5 = f7b5;
    func7_bit0 = f7b0; opcode_bit5 = opb5; md_done = done;
    mop = v && aop == 3'd0 && opb5 && f7b0;
    @(negedge clk);
    chk("alusel", 32'(ALUSel), 32'(ref_sel(v, aop, f3, f7b5, f7b0, opb5)));
    chk("stall", 32'(stall), 32'(age > 0 || (!done_m && age == 0 && mop)));
    chk("md_start", 32'(md_start), 32'(start_m));
    chk("md_op", 32'(md_op), 32'(op_m));
    chk("md_result_sel", 32'(md_result_sel), 32'(done_m));
    chk("md_error", 32'(md_error), 32'(err_m));
    last_sel = ALUSel; last_stall = stall; last_start = md_start;
    last_rsel = md_result_sel; last_err = md_error; last_op = md_op;
    @(posedge clk);
    if (done_m) begin
      done_m = 0;
    end else if (age > 0) begin
      start_m = 0;
      if (done) begin
        age = 0; done_m = 1;
      end else if (age == TO) begin
        age = 0; done_m = 1; err_m = 1;
      end else begin
        age++;
      end
    end else if (mop) begin
      age = 1; start_m = 1; op_m = f3;
    end
    #1;
  endtask

  typedef struct {
    logic [2:0] aop;
    logic [2:0] f3;
    bit         f7b5;
    bit         opb5;
    logic [AW-1:0] exp;
  } vec_t;

  vec_t vt [$];

  // run an M op (func3=f3) with md_done at cycle done_at (-1: never); instruction held until
  // hold_to, then idle; returns counts over ncyc cycles
  task automatic mseq(input logic [2:0] f3, input int done_at, input int hold_to, input int ncyc,
                      output int n_stall, output int n_start, output int rsel_at, output int err_at);
    n_stall = 0; n_start = 0; rsel_at = -1; err_at = -1;
    for (int i = 0; i < ncyc; i++) begin
      cycle(i <= hold_to, 3'd0, f3, 1'b0, 1'b1, 1'b1, i == done_at);
      if (last_stall) n_stall++;
      if (last_start) n_start++;
      if (last_rsel && rsel_at < 0) rsel_at = i;
      if (last_err && err_at < 0) err_at = i;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ns, nst, rs, ea;
    rst = 1'b1; instr_valid = 0; ALUOp = 0; func3 = 0; func7_bit5 = 0;
    func7_bit0 = 0; opcode_bit5 = 0; md_done = 0;
    model_reset();
    #12;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_md_start", 32'(md_start), 0);
    chk("rst_md_op", 32'(md_op), 0);
    chk("rst_md_error", 32'(md_error), 0);
    chk("rst_rsel", 32'(md_result_sel), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    vt = '{
      '{3'd0, 3'd3, 1'b0, 1'b0, 5'd9},  '{3'd0, 3'd0, 1'b1, 1'b1, 5'd1},
      '{3'd0, 3'd0, 1'b1, 1'b0, 5'd0},  '{3'd0, 3'd0, 1'b0, 1'b1, 5'd0},
      '{3'd4, 3'd5, 1'b0, 1'b1, 5'd10}, '{3'd4, 3'd5, 1'b0, 1'b0, 5'd0},
      '{3'd1, 3'd3, 1'b1, 1'b1, 5'd0},  '{3'd0, 3'd5, 1'b1, 1'b0, 5'd5},
      '{3'd0, 3'd5, 1'b0, 1'b1, 5'd4},  '{3'd0, 3'd1, 1'b0, 1'b0, 5'd2},
      '{3'd0, 3'd2, 1'b1, 1'b1, 5'd8},  '{3'd0, 3'd4, 1'b0, 1'b0, 5'd3},
      '{3'd0, 3'd6, 1'b1, 1'b1, 5'd6},  '{3'd0, 3'd7, 1'b0, 1'b1, 5'd7},
      '{3'd2, 3'd7, 1'b1, 1'b1, 5'd0},  '{3'd3, 3'd5, 1'b1, 1'b0, 5'd0},
      '{3'd5, 3'd1, 1'b0, 1'b1, 5'd0},  '{3'd7, 3'd0, 1'b1, 1'b1, 5'd0}
    };
    foreach (vt[k]) begin
      cycle(1'b0, vt[k].aop, vt[k].f3, vt[k].f7b5, 1'b1, vt[k].opb5, 1'b0);
      chk("table_alusel", 32'(last_sel), 32'(vt[k].exp));
    end

    for (int c = 0; c < 256; c++) begin
      logic [7:0] cv;
      cv = 8'(c);
      cycle(1'b0, cv[2:0], cv[5:3], cv[6], cv[6] ^ cv[7], cv[7], 1'b0);
    end

    // DIVU, done in the start cycle; stray md_done afterwards in IDLE
    mseq(3'd5, 1, 2, 2, ns, nst, rs, ea);
    chk("divu_alusel_mop", 32'(last_sel), 0);
    cycle(1'b1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("divu_rsel_done", 32'(last_rsel), 1);
    chk("divu_stall_done", 32'(last_stall), 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("divu_stall_cnt", 32'(ns), 2);
    chk("stray_done_ignored", 32'(last_stall | last_start | last_rsel), 0);

    // MUL with md_done three cycles after md_start
    mseq(3'd0, 4, 5, 8, ns, nst, rs, ea);
    chk("mul_stall_cnt", 32'(ns), 5);
    chk("mul_start_cnt", 32'(nst), 1);
    chk("mul_rsel_at", 32'(rs), 5);
    chk("mul_md_op", 32'(last_op), 0);
    chk("mul_err", 32'(ea), 32'(-1));

    // md_done exactly on the last counter value: done wins
    mseq(3'd1, 8, 9, 11, ns, nst, rs, ea);
    chk("edge_rsel_at", 32'(rs), 9);
    chk("edge_no_err", 32'(ea), 32'(-1));

    // two back-to-back REM ops
    mseq(3'd6, -1, -1, 0, ns, nst, rs, ea);
    nst = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(i <= 5, 3'd0, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1);
      if (last_start) nst++;
      if (i == 4) chk("rem2_start", 32'(last_start), 1);
      if (i == 4) chk("rem2_md_op", 32'(last_op), 6);
      if (i == 3) chk("rem_gap_idle_stall", 32'(last_stall), 1);
    end
    chk("rem_start_cnt", 32'(nst), 2);

    // timeout: md_done never arrives
    mseq(3'd0, -1, 9, 12, ns, nst, rs, ea);
    chk("to_err_at", 32'(ea), 9);
    chk("to_rsel_at", 32'(rs), 9);
    chk("to_stall_cnt", 32'(ns), 9);
    mseq(3'd0, 2, 3, 5, ns, nst, rs, ea);
    chk("err_sticky", 32'(ea), 0);
    chk("err_no_block", 32'(rs), 3);

    // asynchronous reset in the middle of BUSY
    cycle(1'b1, 3'd0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    instr_valid = 1'b0;
    #2; rst = 1'b1; #1;
    chk("arst_stall", 32'(stall), 0);
    chk("arst_md_start", 32'(md_start), 0);
    chk("arst_md_error", 32'(md_error), 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mseq(3'd7, -1, 9, 11, ns, nst, rs, ea);
    chk("post_rst_to_err_at", 32'(ea), 9);

    for (int i = 0; i < 700; i++) begin
      logic [2:0] aop;
      aop = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      cycle($urandom_range(0, 5) != 0, aop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
